// File: rtl/vga_interface.sv
// 1280x720@60 Hz (CEA-861 720p) timing generator with a registered RGB565 pass-through.
// Pixels are taken from upstream only while rdy is high; there is no frame storage.
module vga_interface #(
  parameter int H_SYNC = 40,
  parameter int H_BP   = 220,
  parameter int H_AP   = 1280,
  parameter int H_FP   = 110,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 20,
  parameter int V_AP   = 720,
  parameter int V_FP   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_vld,
  output logic        rdy,
  output logic [15:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync
);

  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BP + H_AP);
  localparam logic [10:0] H_LAST     = 11'(H_SYNC + H_BP + H_AP + H_FP - 1);
  localparam logic [9:0]  V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0]  V_ACT_BEG  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_ACT_END  = 10'(V_SYNC + V_BP + V_AP);
  localparam logic [9:0]  V_LAST     = 10'(V_SYNC + V_BP + V_AP + V_FP - 1);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_vld;
  logic        v_vld;
  logic        h_last;
  logic        v_last;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);
  assign h_vld  = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
  assign v_vld  = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
  assign rdy    = h_vld && v_vld;

  // The line counter wraps every H_TOTAL clocks and carries into the frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= 11'd0;
      v_cnt <= 10'd0;
    end else if (h_last) begin
      h_cnt <= 11'd0;
      v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Syncs are registered alongside the pixel so all DAC inputs share one cycle of delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_rgb   <= 16'h0000;
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
    end else begin
      vga_rgb   <= (rdy && din_vld) ? din : 16'h0000;
      vga_hsync <= (h_cnt < H_SYNC_END);
      vga_vsync <= (v_cnt < V_SYNC_END);
    end
  end

endmodule

// File: tb/tb_vga_interface.sv
// Directed bench for vga_interface: full-size timing around reset and the first active
// lines, plus a shrunken instance that runs whole frames, including the frame wrap.
module tb_vga_interface;

  logic        clk = 1'b0;
  logic        rst, rst_s;
  logic [15:0] din, din_s;
  logic        din_vld, din_vld_s;
  logic        rdy, rdy_s;
  logic [15:0] vga_rgb, vga_rgb_s;
  logic        vga_hsync, vga_vsync, vga_hsync_s, vga_vsync_s;

  int checks   = 0;
  int failures = 0;
  int k  = 0;
  int ks = 0;

  always #5 clk = ~clk;

  vga_interface dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .rdy(rdy),
    .vga_rgb(vga_rgb), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  // Small geometry: 25 clocks per line, 11 lines per frame, 275 clocks per frame.
  vga_interface #(
    .H_SYNC(4), .H_BP(6), .H_AP(10), .H_FP(5),
    .V_SYNC(2), .V_BP(3), .V_AP(4), .V_FP(2)
  ) dut_s (
    .clk(clk), .rst(rst_s), .din(din_s), .din_vld(din_vld_s), .rdy(rdy_s),
    .vga_rgb(vga_rgb_s), .vga_hsync(vga_hsync_s), .vga_vsync(vga_vsync_s)
  );

  function automatic logic exp_rdy(int n);
    int h = n % 1650;
    int v = (n / 1650) % 750;
    return (h >= 260) && (h < 1540) && (v >= 25) && (v < 745);
  endfunction

  function automatic logic exp_rdy_s(int n);
    int h = n % 25;
    int v = (n / 25) % 11;
    return (h >= 10) && (h < 20) && (v >= 5) && (v < 9);
  endfunction

  // k / ks count edges since reset release, so they equal the expected counter position.
  task automatic step;
    @(posedge clk);
    if (rst) k = 0; else k++;
    if (rst_s) ks = 0; else ks++;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst_s = 1'b1;
    din = 16'h0; din_vld = 1'b0; din_s = 16'h0; din_vld_s = 1'b0;
    repeat (3) step;
    checks++; if (vga_rgb !== 16'h0) begin failures++; $display("[TB] FAIL reset_rgb got=%h exp=0000", vga_rgb); end
    checks++; if (vga_hsync !== 1'b0) begin failures++; $display("[TB] FAIL reset_hsync got=%b exp=0", vga_hsync); end
    checks++; if (vga_vsync !== 1'b0) begin failures++; $display("[TB] FAIL reset_vsync got=%b exp=0", vga_vsync); end
    checks++; if (dut.h_cnt !== 11'd0) begin failures++; $display("[TB] FAIL reset_h_cnt got=%0d exp=0", dut.h_cnt); end
    checks++; if (dut.v_cnt !== 10'd0) begin failures++; $display("[TB] FAIL reset_v_cnt got=%0d exp=0", dut.v_cnt); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdy got=%b exp=0", rdy); end
    rst = 1'b0;
    step;
    checks++; if (vga_hsync !== 1'b1) begin failures++; $display("[TB] FAIL release_hsync got=%b exp=1", vga_hsync); end
    checks++; if (vga_vsync !== 1'b1) begin failures++; $display("[TB] FAIL release_vsync got=%b exp=1", vga_vsync); end
    checks++; if (dut.h_cnt !== 11'd1) begin failures++; $display("[TB] FAIL release_h_cnt got=%0d exp=1", dut.h_cnt); end
  endtask

  task automatic test_line_timing;
    int   hs_high  = 0;
    int   vs_high  = 0;
    int   rdy_high = 0;
    int   rise_k   = -1;
    logic prev_hs  = vga_hsync;
    while (k < 9000) begin
      if (k <= 1650 && vga_hsync) hs_high++;
      if (vga_vsync) vs_high++;
      if (rdy) rdy_high++;
      step;
      if (!prev_hs && vga_hsync && rise_k < 0) rise_k = k;
      prev_hs = vga_hsync;
    end
    checks++; if (hs_high !== 40) begin failures++; $display("[TB] FAIL hsync_width got=%0d exp=40", hs_high); end
    checks++; if (rise_k - 1 !== 1650) begin failures++; $display("[TB] FAIL hsync_period got=%0d exp=1650", rise_k - 1); end
    checks++; if (vs_high !== 8250) begin failures++; $display("[TB] FAIL vsync_width got=%0d exp=8250", vs_high); end
    checks++; if (rdy_high !== 0) begin failures++; $display("[TB] FAIL rdy_in_vblank got=%0d exp=0", rdy_high); end
  endtask

  task automatic test_first_active;
    while (!rdy && k < 50000) step;
    checks++; if (k !== 41510) begin failures++; $display("[TB] FAIL first_rdy_cycle got=%0d exp=41510", k); end
    checks++; if (dut.h_cnt !== 11'd260) begin failures++; $display("[TB] FAIL first_rdy_h got=%0d exp=260", dut.h_cnt); end
    checks++; if (dut.v_cnt !== 10'd25) begin failures++; $display("[TB] FAIL first_rdy_v got=%0d exp=25", dut.v_cnt); end
    checks++; if (dut.h_vld !== 1'b1 || dut.v_vld !== 1'b1) begin
      failures++; $display("[TB] FAIL first_rdy_vld got=%b%b exp=11", dut.h_vld, dut.v_vld);
    end
  endtask

  task automatic test_pass_through;
    logic [15:0] exp_px;
    int          rdy_cnt = 0;
    for (int i = 0; i <= 1280; i++) begin
      if (rdy) rdy_cnt++;
      din     = 16'($urandom);
      din_vld = 1'b1;
      exp_px  = (i < 1280) ? din : 16'h0000;
      step;
      checks++;
      if (vga_rgb !== exp_px) begin
        failures++; $display("[TB] FAIL pass_px%0d got=%h exp=%h", i, vga_rgb, exp_px);
      end
    end
    din_vld = 1'b0;
    checks++; if (rdy_cnt !== 1280) begin failures++; $display("[TB] FAIL rdy_per_line got=%0d exp=1280", rdy_cnt); end
  endtask

  task automatic test_gap;
    logic [15:0] exp_px;
    din_vld = 1'b0;
    while (!rdy && k < 45000) step;
    checks++; if (k !== 43160) begin failures++; $display("[TB] FAIL gap_line_start got=%0d exp=43160", k); end
    for (int i = 0; i < 1280; i++) begin
      din     = 16'($urandom);
      din_vld = !(i >= 100 && i < 200);
      exp_px  = din_vld ? din : 16'h0000;
      step;
      checks++;
      if (vga_rgb !== exp_px) begin
        failures++; $display("[TB] FAIL gap_px%0d got=%h exp=%h", i, vga_rgb, exp_px);
      end
    end
  endtask

  task automatic test_blanking_ignore;
    din = 16'hFFFF; din_vld = 1'b1;
    repeat (3300) begin
      step;
      checks++;
      if (vga_rgb !== (exp_rdy(k - 1) ? 16'hFFFF : 16'h0000)) begin
        failures++; $display("[TB] FAIL blank_rgb at=%0d got=%h exp=%h", k, vga_rgb, exp_rdy(k - 1) ? 16'hFFFF : 16'h0000);
      end
      checks++;
      if (rdy !== exp_rdy(k)) begin
        failures++; $display("[TB] FAIL blank_rdy at=%0d got=%b exp=%b", k, rdy, exp_rdy(k));
      end
    end
  endtask

  task automatic test_mid_reset;
    rst = 1'b1;
    step;
    checks++; if (dut.h_cnt !== 11'd0 || dut.v_cnt !== 10'd0) begin
      failures++; $display("[TB] FAIL midrst_cnt got=%0d,%0d exp=0,0", dut.h_cnt, dut.v_cnt);
    end
    checks++; if (vga_rgb !== 16'h0 || vga_hsync !== 1'b0 || vga_vsync !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_out got=%h/%b/%b exp=0000/0/0", vga_rgb, vga_hsync, vga_vsync);
    end
    rst = 1'b0;
    step;
    checks++; if (vga_hsync !== 1'b1 || vga_vsync !== 1'b1 || vga_rgb !== 16'h0) begin
      failures++; $display("[TB] FAIL midrst_restart got=%h/%b/%b exp=0000/1/1", vga_rgb, vga_hsync, vga_vsync);
    end
    checks++; if (dut.h_cnt !== 11'd1 || dut.v_cnt !== 10'd0) begin
      failures++; $display("[TB] FAIL midrst_restart_cnt got=%0d,%0d exp=1,0", dut.h_cnt, dut.v_cnt);
    end
    din_vld = 1'b0;
  endtask

  task automatic test_small_frames;
    logic [15:0] exp_px;
    logic        exp_hs, exp_vs;
    int          vs_high  = 0;
    int          rdy_high = 0;
    rst_s = 1'b1;
    step; step;
    rst_s = 1'b0;
    while (ks < 3 * 275 + 1) begin
      checks++;
      if (rdy_s !== exp_rdy_s(ks)) begin
        failures++; $display("[TB] FAIL small_rdy at=%0d got=%b exp=%b", ks, rdy_s, exp_rdy_s(ks));
      end
      if (ks >= 275 && ks < 550 && rdy_s) rdy_high++;
      din_s     = 16'($urandom);
      din_vld_s = exp_rdy_s(ks);
      exp_px    = exp_rdy_s(ks) ? din_s : 16'h0000;
      exp_hs    = (ks % 25) < 4;
      exp_vs    = ((ks / 25) % 11) < 2;
      step;
      if (ks <= 275 && vga_vsync_s) vs_high++;
      checks++;
      if (vga_rgb_s !== exp_px || vga_hsync_s !== exp_hs || vga_vsync_s !== exp_vs) begin
        failures++;
        $display("[TB] FAIL small_out at=%0d got=%h/%b/%b exp=%h/%b/%b",
                 ks, vga_rgb_s, vga_hsync_s, vga_vsync_s, exp_px, exp_hs, exp_vs);
      end
      if (ks == 275) begin
        checks++;
        if (dut_s.h_cnt !== 11'd0 || dut_s.v_cnt !== 10'd0) begin
          failures++; $display("[TB] FAIL small_wrap got=%0d,%0d exp=0,0", dut_s.h_cnt, dut_s.v_cnt);
        end
      end
    end
    din_vld_s = 1'b0;
    checks++; if (vs_high !== 50) begin failures++; $display("[TB] FAIL small_vsync_width got=%0d exp=50", vs_high); end
    checks++; if (rdy_high !== 40) begin failures++; $display("[TB] FAIL small_rdy_per_frame got=%0d exp=40", rdy_high); end
  endtask

  initial begin
    test_reset;
    test_line_timing;
    test_first_active;
    test_pass_through;
    test_gap;
    test_blanking_ignore;
    test_mid_reset;
    test_small_frames;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
